// File: rtl/sub32_nser.sv
// Nibble-serial subtractor: d = a - b - bi, with borrow-out bo.
// The operands are latched when start is accepted. One SLICE-bit borrow-lookahead slice is
// evaluated per cycle, LSB slice first, and the borrow is registered between slices.
// Optional feature macro: SUB32_OVF_EN drives v with the signed overflow flag. Without it,
// v is tied to 0.
// WIDTH must be a multiple of SLICE, and WIDTH/SLICE must be at least 2.
module sub32_nser #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bo,
   output logic             v
);

   localparam int unsigned NSL = WIDTH / SLICE;
   localparam int unsigned KW  = (NSL > 1) ? $clog2(NSL) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NSL - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t                 state;
   logic [WIDTH-1:0]       a_r;
   logic [WIDTH-1:0]       b_r;
   logic [WIDTH-SLICE-1:0] res;     // finished slices collect here, newest at the top
   logic                   brw;
   logic [KW-1:0]          k;

   logic [SLICE-1:0]       sa;
   logic [SLICE-1:0]       sb;
   logic [SLICE-1:0]       g;
   logic [SLICE-1:0]       p;
   logic [SLICE-1:0]       sdiff;
   logic [SLICE:0]         c;
   logic [WIDTH-1:0]       d_next;
   logic                   pp;

`ifdef SUB32_OVF_EN
   logic v_r;
   assign v = v_r;
`else
   assign v = 1'b0;
`endif

   // Current slice: sum-of-products borrow lookahead from generate/propagate.
   always_comb begin
      sa = a_r[32'(k) * SLICE +: SLICE];
      sb = b_r[32'(k) * SLICE +: SLICE];
      g  = ~sa & sb;
      p  = ~(sa ^ sb);
      c  = '0;
      pp = 1'b1;
      c[0] = brw;
      for (int i = 1; i <= SLICE; i++) begin
         pp = 1'b1;
         for (int j = i - 1; j >= 0; j--) begin
            c[i] = c[i] | (g[j] & pp);
            pp   = pp & p[j];
         end
         c[i] = c[i] | (pp & brw);
      end
      sdiff  = sa ^ sb ^ c[SLICE-1:0];
      d_next = {sdiff, res};
   end

   // Control FSM, operand and slice state, and the registered result outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= StIdle;
         busy  <= 1'b0;
         done  <= 1'b0;
         d     <= '0;
         bo    <= 1'b0;
         a_r   <= '0;
         b_r   <= '0;
         res   <= '0;
         brw   <= 1'b0;
         k     <= '0;
`ifdef SUB32_OVF_EN
         v_r   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  a_r   <= a;
                  b_r   <= b;
                  brw   <= bi;
                  k     <= '0;
                  busy  <= 1'b1;
                  state <= StRun;
               end else begin
                  state <= StIdle;
               end
            end
            StRun: begin
               res <= d_next[WIDTH-1:SLICE];
               brw <= c[SLICE];
               k   <= k + 1'b1;
               if (k == KLAST) begin
                  d     <= d_next;
                  bo    <= c[SLICE];
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= StDone;
`ifdef SUB32_OVF_EN
                  v_r   <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (a_r[WIDTH-1] ^ d_next[WIDTH-1]);
`endif
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sub32_nser.sv
// Self-checking bench for sub32_nser (default 32/4 build). Expected results come from
// 33-bit unsigned and 64-bit signed arithmetic on the applied operands.
module tb_sub32_nser;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        bi;
   logic        busy;
   logic        done;
   logic [31:0] d;
   logic        bo;
   logic        v;

   int nchk = 0;
   int nerr = 0;

   sub32_nser dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .bi      (bi),
      .busy    (busy),
      .done    (done),
      .d       (d),
      .bo      (bo),
      .v       (v)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [32:0] ref_sub(input logic [31:0] x, input logic [31:0] y,
                                           input logic z);
      return {1'b0, x} - {1'b0, y} - {32'd0, z};
   endfunction

   function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y, input logic z);
`ifdef SUB32_OVF_EN
      longint sx;
      longint sy;
      longint r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r  = sx - sy - longint'(z);
      return (r > 64'sd2147483647) || (r < -64'sd2147483648);
`else
      return 1'b0;
`endif
   endfunction

   // One full operation from an idle or done state, with latency and hold checks.
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic tbi,
                         input string tag);
      logic [32:0] r;
      logic [31:0] dhold;
      logic        moved;
      int          lat;
      r     = ref_sub(ta, tb, tbi);
      a     = ta;
      b     = tb;
      bi    = tbi;
      start = 1'b1;
      dhold = d;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      bi    = 1'($urandom_range(0, 1));
      lat   = 0;
      moved = 1'b0;
      while (!done && lat < 20) begin
         if (d !== dhold) moved = 1'b1;
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, ".latency"}, 64'(lat), 64'd8);
      chk({tag, ".hold"}, 64'(moved), 64'd0);
      chk({tag, ".d"}, 64'(d), 64'(r[31:0]));
      chk({tag, ".bo"}, 64'(bo), 64'(r[32]));
      chk({tag, ".v"}, 64'(v), 64'(ref_ovf(ta, tb, tbi)));
   endtask

   initial begin
      logic [32:0] exp_r;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic        exp_bi;
      int          prev;
      int          ndone;
      int          wait_n;
      logic [31:0] ra;
      logic [31:0] rb;

      reset_n = 1'b0;
      start   = 1'b0;
      a       = 32'd0;
      b       = 32'd0;
      bi      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.busy", 64'(busy), 64'd0);
      chk("reset.done", 64'(done), 64'd0);
      chk("reset.d", 64'(d), 64'd0);
      chk("reset.bo", 64'(bo), 64'd0);
      chk("reset.v", 64'(v), 64'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      run_op(32'h0000_0005, 32'd3, 1'b0, "5m3");
      run_op(32'd3, 32'd5, 1'b0, "3m5");
      run_op(32'd7, 32'd7, 1'b1, "7m7b");
      run_op(32'h1000_0000, 32'd1, 1'b0, "bchain");
      run_op(32'd0, 32'd0, 1'b0, "zero");
      run_op(32'h8000_0000, 32'd1, 1'b0, "ovf");
      run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, "ovfpos");

      // start held high: one done every 9 cycles; operands offered while busy are ignored.
      exp_a  = $urandom;
      exp_b  = $urandom;
      exp_bi = 1'($urandom_range(0, 1));
      a      = exp_a;
      b      = exp_b;
      bi     = exp_bi;
      exp_r  = ref_sub(exp_a, exp_b, exp_bi);
      start  = 1'b1;
      prev   = -1;
      ndone  = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(posedge clk);
         #1;
         if (done) begin
            chk("b2b.d", 64'(d), 64'(exp_r[31:0]));
            chk("b2b.bo", 64'(bo), 64'(exp_r[32]));
            chk("b2b.v", 64'(v), 64'(ref_ovf(exp_a, exp_b, exp_bi)));
            if (prev >= 0) chk("b2b.interval", 64'(cyc - prev), 64'd9);
            prev = cyc;
            ndone++;
         end
         ra = $urandom;
         rb = $urandom;
         a  = ra;
         b  = rb;
         bi = 1'($urandom_range(0, 1));
         if (done) begin
            exp_a  = ra;
            exp_b  = rb;
            exp_bi = bi;
            exp_r  = ref_sub(ra, rb, bi);
         end
      end
      chk("b2b.count", 64'(ndone), 64'd4);
      start  = 1'b0;
      wait_n = 0;
      while ((busy || done) && wait_n < 20) begin
         @(posedge clk);
         #1;
         wait_n++;
      end
      chk("b2b.drain", 64'(busy), 64'd0);

      // Reset during RUN aborts: no done pulse and the outputs clear.
      run_op(32'hDEAD_BEEF, 32'h0000_1111, 1'b0, "prerst");
      a     = 32'hFFFF_FFFF;
      b     = 32'd1;
      bi    = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      chk("abort.busy", 64'(busy), 64'd0);
      chk("abort.done", 64'(done), 64'd0);
      chk("abort.d", 64'(d), 64'd0);
      chk("abort.bo", 64'(bo), 64'd0);
      chk("abort.v", 64'(v), 64'd0);
      ndone = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      chk("abort.nodone", 64'(ndone), 64'd0);

      // Random operands, biased towards equal and small values.
      for (int n = 0; n < 2000; n++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       begin ra = 32'($urandom_range(0, 15)); rb = 32'($urandom_range(0, 15)); end
            default: ;
         endcase
         run_op(ra, rb, 1'($urandom_range(0, 1)), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

endmodule
